// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: fetch FSM states, opcode field position,
// ControlSignals bit indices and the default reset PC.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } fetch_state_t;

    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_W   = 6;

    localparam int unsigned CTRL_JUMP   = 9;
    localparam int unsigned CTRL_BRANCH = 2;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/mips_next_pc.sv
// Combinational next-PC selection: jump beats taken branch beats pc+4.
module mips_next_pc #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26,
    output logic [ADDR_W-1:0] next_pc
);

    logic [ADDR_W-1:0] jump_pc;
    logic [ADDR_W-1:0] branch_pc;

    // With a 28-bit address space the jump target covers every bit, so there is no region to keep.
    generate
        if (ADDR_W > 28) begin : g_region
            assign jump_pc = {pc_plus4[ADDR_W-1:28], target26, 2'b00};
        end else begin : g_flat
            assign jump_pc = {target26, 2'b00};
        end
    endgenerate

    assign branch_pc = pc_plus4 + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_pc;
        end else if (branch_taken) begin
            next_pc = branch_pc;
        end
    end

endmodule

// File: rtl/mips_fetch_stage.sv
// MIPS instruction-fetch stage: PC, req/ack fetch from imem, instruction register.
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count outputs.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic              instr_valid,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              commit,
    input  logic              jump,
    input  logic              branch_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       target26
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count,
    output logic [31:0]       stall_count
`endif
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] next_pc;
    logic [31:0]       instr_q;
    logic              load_instr;
    logic              load_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_instr = 1'b0;
        load_pc    = 1'b0;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (commit) begin
                    load_pc = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            if (load_pc) begin
                pc_q <= next_pc;
            end
            if (load_instr) begin
                instr_q <= imem_rdata;
            end
        end
    end

    mips_next_pc #(
        .ADDR_W(ADDR_W)
    ) u_next_pc (
        .pc_plus4    (pc_plus4),
        .jump        (jump),
        .branch_taken(branch_taken),
        .imm16       (imm16),
        .target26    (target26),
        .next_pc     (next_pc)
    );

    assign imem_req    = (state_q == FETCH);
    assign instr_valid = (state_q == HOLD);
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + ADDR_W'(4);
    assign instr       = instr_q;
    assign opcode      = instr_q[OPCODE_LSB +: OPCODE_W];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else if (state_q == FETCH) begin
            if (imem_ack) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Scoreboard bench for mips_fetch_stage: three lockstep instances with different RESET_PC
// share all stimulus; expected fetch addresses and instruction words are queued and popped.
module tb_mips_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        commit;
    logic        jump;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] target26;

    logic        req_a, req_b, req_c;
    logic [31:0] addr_a, addr_b, addr_c;
    logic [31:0] instr_a, instr_b, instr_c;
    logic [5:0]  op_a, op_b, op_c;
    logic        val_a, val_b, val_c;
    logic [31:0] pc_a, pc_b, pc_c;
    logic [31:0] p4_a, p4_b, p4_c;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc_a, fc_b, fc_c;
    logic [31:0] sc_a, sc_b, sc_c;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } trip_t;

    trip_t       q_addr[$];
    logic [31:0] q_instr[$];
    logic [31:0] m_a, m_b, m_c;
    logic [31:0] exp_fetch, exp_stall;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    mips_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_a (
        .clk(clk), .rst_n(rst_n), .imem_req(req_a), .imem_addr(addr_a), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr_a), .opcode(op_a), .instr_valid(val_a), .pc(pc_a),
        .pc_plus4(p4_a), .commit(commit), .jump(jump), .branch_taken(branch_taken),
        .imm16(imm16), .target26(target26)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc_a), .stall_count(sc_a)
`endif
    );

    mips_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h3000_0000)) u_b (
        .clk(clk), .rst_n(rst_n), .imem_req(req_b), .imem_addr(addr_b), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr_b), .opcode(op_b), .instr_valid(val_b), .pc(pc_b),
        .pc_plus4(p4_b), .commit(commit), .jump(jump), .branch_taken(branch_taken),
        .imm16(imm16), .target26(target26)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc_b), .stall_count(sc_b)
`endif
    );

    mips_fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_c (
        .clk(clk), .rst_n(rst_n), .imem_req(req_c), .imem_addr(addr_c), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr_c), .opcode(op_c), .instr_valid(val_c), .pc(pc_c),
        .pc_plus4(p4_c), .commit(commit), .jump(jump), .branch_taken(branch_taken),
        .imm16(imm16), .target26(target26)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_count(fc_c), .stall_count(sc_c)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mdl_next(input logic [31:0] cur, input logic j, input logic bt,
                                             input logic [15:0] imm, input logic [25:0] tgt);
        logic [31:0] seq;
        logic [31:0] off;
        seq = cur + 32'd4;
        off = {{14{imm[15]}}, imm, 2'b00};
        if (j)  return {seq[31:28], tgt, 2'b00};
        if (bt) return seq + off;
        return seq;
    endfunction

    task automatic pop_addr(output trip_t t);
        if (q_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_addr: got=empty exp=entry");
            t = '0;
        end else begin
            t = q_addr.pop_front();
            check("addr_a", addr_a, t.a);
            check("addr_b", addr_b, t.b);
            check("addr_c", addr_c, t.c);
        end
    endtask

    task automatic check_perf();
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", fc_a, exp_fetch);
        check("stall_count", sc_a, exp_stall);
        check("fetch_count_c", fc_c, exp_fetch);
`endif
    endtask

    // Called at a negedge; rst_n asserts immediately, stray ack is driven during the BOOT cycle.
    task automatic apply_reset(input logic stray);
        rst_n = 1'b0;
        imem_ack = 1'b0;
        commit = 1'b0;
        #1;
        check("rst_req", req_a, 0);
        check("rst_valid", val_a, 0);
        check("rst_instr", instr_a, 0);
        check("rst_opcode", op_a, 0);
        check("rst_pc_a", pc_a, 32'h0000_0000);
        check("rst_pc_b", pc_b, 32'h3000_0000);
        check("rst_pc_c", pc_c, 32'hFFFF_FFFC);
        exp_fetch = '0;
        exp_stall = '0;
        check_perf();
        m_a = 32'h0000_0000;
        m_b = 32'h3000_0000;
        m_c = 32'hFFFF_FFFC;
        q_addr.delete();
        q_instr.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot_req", req_a, 0);
        imem_ack = stray;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check("boot_valid", val_a, 0);
        check("boot_to_fetch_req", req_a, 1);
        q_addr.push_back({m_a, m_b, m_c});
    endtask

    // Precondition: negedge, instances just entered FETCH.
    task automatic do_fetch(input int unsigned waits, input logic [31:0] word);
        trip_t       ea;
        logic [31:0] ei;
        check("fetch_req", req_a, 1);
        pop_addr(ea);
        for (int unsigned i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            commit = 1'b1;
            jump = 1'b1;
            @(posedge clk);
            @(negedge clk);
            exp_stall++;
            check("wait_req", req_a, 1);
            check("wait_valid", val_a, 0);
            check("wait_addr", addr_a, ea.a);
        end
        commit = 1'b0;
        jump = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = word;
        q_instr.push_back(word);
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        exp_fetch++;
        check("hold_valid", val_a, 1);
        check("hold_req", req_a, 0);
        check("hold_pc", pc_a, ea.a);
        check("hold_pc4", p4_a, ea.a + 32'd4);
        if (q_instr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_instr: got=empty exp=entry");
        end else begin
            ei = q_instr.pop_front();
            check("instr", instr_a, ei);
            check("opcode", {26'd0, op_a}, {26'd0, ei[31:26]});
        end
        check_perf();
    endtask

    // Precondition: negedge, instances in HOLD.
    task automatic do_commit(input logic j, input logic bt, input logic [15:0] imm, input logic [25:0] tgt);
        m_a = mdl_next(m_a, j, bt, imm, tgt);
        m_b = mdl_next(m_b, j, bt, imm, tgt);
        m_c = mdl_next(m_c, j, bt, imm, tgt);
        q_addr.push_back({m_a, m_b, m_c});
        commit = 1'b1;
        jump = j;
        branch_taken = bt;
        imm16 = imm;
        target26 = tgt;
        @(posedge clk);
        @(negedge clk);
        commit = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        imm16 = 16'h0;
        target26 = 26'h0;
        check("commit_valid", val_a, 0);
        check("commit_req", req_a, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        trip_t ea;
        rst_n = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        commit = 1'b0;
        jump = 1'b0;
        branch_taken = 1'b0;
        imm16 = '0;
        target26 = '0;
        exp_fetch = '0;
        exp_stall = '0;
        @(negedge clk);
        apply_reset(1'b0);

        do_fetch(2, 32'h8C01_0004);
        do_commit(1'b0, 1'b0, 16'h0, 26'h0);
        check("wrap_c", addr_c, 32'h0000_0000);
        do_fetch(0, 32'h0000_0020);
        do_commit(1'b0, 1'b0, 16'h0, 26'h0);
        do_fetch(0, 32'h1000_0003);

        // HOLD ignores a stray ack and keeps the instruction register.
        imem_ack = 1'b1;
        imem_rdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        check("idle_valid", val_a, 1);
        check("idle_req", req_a, 0);
        check("idle_instr", instr_a, 32'h1000_0003);

        do_commit(1'b0, 1'b0, 16'h0, 26'h0);
        do_fetch(0, 32'h2001_0001);
        do_commit(1'b0, 1'b0, 16'h0, 26'h0);
        do_fetch(1, 32'h1022_FFFC);
        check("pc_0x10", pc_a, 32'h0000_0010);
        do_commit(1'b0, 1'b1, 16'hFFFC, 26'h0);
        check("beq_back", addr_a, 32'h0000_0004);
        do_fetch(0, 32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            do_commit(1'b0, 1'b0, 16'h0, 26'h0);
            do_fetch(0, 32'h0000_0000 | (k << 26));
        end
        do_commit(1'b0, 1'b1, 16'h0003, 26'h3FF_FFFF);
        check("beq_fwd", addr_a, 32'h0000_0020);
        do_fetch(0, 32'h0800_0040);

        apply_reset(1'b0);
        do_fetch(0, 32'h0800_0040);
        do_commit(1'b1, 1'b1, 16'h1234, 26'h000_0040);
        check("jump_b", addr_b, 32'h3000_0100);
        check("jump_a", addr_a, 32'h0000_0100);

        // Reset while the request is still outstanding.
        check("pend_req", req_a, 1);
        pop_addr(ea);
        @(posedge clk);
        @(negedge clk);
        check("pend_valid", val_a, 0);
        apply_reset(1'b1);

        do_fetch(0, 32'hAC02_0008);
        do_commit(1'b0, 1'b0, 16'h0, 26'h0);
        do_fetch(3, 32'h3C01_1234);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_fetch_stage.md
Name: mips_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS datapath, directly upstream of the control unit.
- Holds the PC and runs a req/ack handshake with instruction memory.
- Latches the returned word into an instruction register and drives `opcode` (instr[31:26]) to the control unit's OpCode input.
- Computes the next PC (sequential, beq-taken or j) when the downstream core commits the current instruction.

Parameters:
- ADDR_W, 32, PC / memory address width (min 28 so the jump target concatenation is defined).
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until acked
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_ack  in  1  memory returns imem_rdata this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  instruction register
- opcode  out  6  instr[31:26], to control unit OpCode
- instr_valid  out  1  instr/pc hold a fetched instruction
- pc  out  ADDR_W  address of instr
- pc_plus4  out  ADDR_W  pc+4
- commit  in  1  downstream retires instr this cycle (ignored unless instr_valid)
- jump  in  1  control bit 9 (j) for the committing instr
- branch_taken  in  1  Branch & ALU zero for the committing instr
- imm16  in  16  branch offset field (instr[15:0])
- target26  in  26  jump field (instr[25:0])

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT, pc=RESET_PC.
  - instr=0, instr_valid=0, imem_req=0.
  - opcode=0 while instr=0.
- States:
  - BOOT: one cycle, imem_req=0 -> FETCH.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, instr_valid<=1 -> HOLD. A zero-wait memory may ack in the first FETCH cycle.
  - HOLD: imem_req=0, instr_valid=1. On commit: pc<=next_pc, instr_valid<=0 -> FETCH. Otherwise hold all outputs.
- next_pc priority, evaluated only on commit in HOLD:
  1. jump=1: {pc_plus4[ADDR_W-1:28], target26, 2'b00}.
  2. else branch_taken=1: pc_plus4 + (sign_extend(imm16) << 2).
  3. else pc_plus4.
- Arithmetic: all adds are modulo 2^ADDR_W. pc=32'hFFFF_FFFC with a sequential commit wraps to 0.
- Throughput: minimum 2 cycles per instruction with a zero-wait memory (FETCH/ack, HOLD/commit).
- commit outside HOLD is ignored. jump, branch_taken, imm16 and target26 are sampled only with a valid commit.
- jump and branch_taken both high: jump wins.
- imem_ack while imem_req=0 is ignored. No new request issues until the previous one is acked.
- pc is always word aligned; RESET_PC[1:0] must be 0.
- Reset asserted mid-FETCH or mid-HOLD: everything returns immediately to reset values. A late imem_ack is dropped by the BOOT state.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined, two extra outputs:
  - fetch_count [31:0]: increments on each accepted imem_ack.
  - stall_count [31:0]: increments on each FETCH cycle without imem_ack.
  - Both reset to 0, wrap at 2^32, are read-only, and have no effect on fetch behaviour.
- Without the macro: ports and counters are absent; the block is otherwise identical.

Decomposition:
- Shared package mips_pkg:
  - state enum (BOOT/FETCH/HOLD).
  - OPCODE_LSB=26, OPCODE_W=6.
  - Control-bit index constants CTRL_JUMP=9, CTRL_BRANCH=2, so the integrator slices ControlSignals consistently.
  - RESET_PC default.
- One sub-module: mips_next_pc, purely combinational, producing next_pc from pc_plus4, jump, branch_taken, imm16 and target26.

Test Plan:
- Reset then zero-wait memory (ack with req), commit every HOLD cycle -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every second cycle; opcode matches rdata[31:26].
- Memory with a 3-cycle ack delay -> imem_req held 3 cycles at a stable address; instr_valid stays 0 until ack; with the macro, stall_count=2 and fetch_count=1 after the first fetch.
- At pc=0x10, commit with branch_taken=1, imm16=16'hFFFC -> next imem_addr=0x04. At pc=0x10, imm16=16'h0003 -> 0x20.
- At pc=0x3000_0000, commit with jump=1, target26=26'h000_0040, and branch_taken=1 at the same time -> next imem_addr=0x3000_0100 (jump wins).
- RESET_PC=32'hFFFF_FFFC, sequential commit -> next imem_addr=0x0000_0000 (wrap).
- Assert rst_n=0 during HOLD and again while an ack is pending -> instr_valid=0, imem_req=0, pc=RESET_PC immediately; a stray ack one cycle after release does not set instr_valid.
